// File: rtl/hit_detect.sv
// Per-frame hit resolver for a two-player arena: range test, one connection per
// attack, guard/block handling and per-player hitstun counters.
module hit_detect #(
  parameter int X_W            = 10,
  parameter int BODY_W         = 32,
  parameter int REACH          = 40,
  parameter int HITSTUN_FRAMES = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           freeze,
  input  logic [X_W-1:0] pos1_x,
  input  logic [X_W-1:0] pos2_x,
  input  logic           attack1_active,
  input  logic           attack2_active,
  input  logic           guard1,
  input  logic           guard2,
  output logic           hit1_lands,
  output logic           hit2_lands,
  output logic           blocked1,
  output logic           blocked2,
  output logic           stun1,
  output logic           stun2
);

  localparam int G_W = X_W + 2;
  localparam logic signed [G_W-1:0] L_BODY  = G_W'(BODY_W);
  localparam logic signed [G_W-1:0] L_REACH = G_W'(REACH);
  localparam logic [7:0]            L_STUN  = 8'(HITSTUN_FRAMES);

  logic             r_conn1, r_conn2;
  logic [7:0]       r_stun_cnt1, r_stun_cnt2;
  logic             r_hit1, r_hit2, r_blk1, r_blk2;

  logic signed [G_W-1:0] w_gap;
  logic                  w_in_range;
  logic                  w_cand1, w_cand2;
  logic                  w_load1, w_load2;

  // Zero-extend both positions so the difference goes negative when bodies overlap.
  assign w_gap      = $signed({2'b00, pos2_x}) - $signed({2'b00, pos1_x}) - L_BODY;
  assign w_in_range = (w_gap < L_REACH);

  // Both candidates look only at pre-update state, so a trade resolves symmetrically.
  assign w_cand1 = frame_tick & ~freeze & w_in_range & attack1_active & ~r_conn1 &
                   (r_stun_cnt1 == 8'd0) & (r_stun_cnt2 == 8'd0);
  assign w_cand2 = frame_tick & ~freeze & w_in_range & attack2_active & ~r_conn2 &
                   (r_stun_cnt1 == 8'd0) & (r_stun_cnt2 == 8'd0);

  // w_load1 stuns P1 (P2 landed), w_load2 stuns P2 (P1 landed).
  assign w_load1 = w_cand2 & ~guard1;
  assign w_load2 = w_cand1 & ~guard2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_conn1     <= 1'b0;
      r_conn2     <= 1'b0;
      r_stun_cnt1 <= 8'd0;
      r_stun_cnt2 <= 8'd0;
      r_hit1      <= 1'b0;
      r_hit2      <= 1'b0;
      r_blk1      <= 1'b0;
      r_blk2      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the same pre-edge state.
      r_hit1 <= w_load2;
      r_hit2 <= w_load1;
      r_blk1 <= w_cand1 & guard2;
      r_blk2 <= w_cand2 & guard1;

      if (!attack1_active)  r_conn1 <= 1'b0;
      else if (w_cand1)     r_conn1 <= 1'b1;

      if (!attack2_active)  r_conn2 <= 1'b0;
      else if (w_cand2)     r_conn2 <= 1'b1;

      if (w_load1)                                r_stun_cnt1 <= L_STUN;
      else if (frame_tick && r_stun_cnt1 != 8'd0) r_stun_cnt1 <= r_stun_cnt1 - 8'd1;

      if (w_load2)                                r_stun_cnt2 <= L_STUN;
      else if (frame_tick && r_stun_cnt2 != 8'd0) r_stun_cnt2 <= r_stun_cnt2 - 8'd1;
    end
  end

  assign hit1_lands = r_hit1;
  assign hit2_lands = r_hit2;
  assign blocked1   = r_blk1;
  assign blocked2   = r_blk2;
  assign stun1      = (r_stun_cnt1 != 8'd0);
  assign stun2      = (r_stun_cnt2 != 8'd0);

endmodule

// File: tb/tb_hit_detect.sv
// Directed bench for hit_detect: single-tick vector table plus multi-tick
// sequences for one-connection, hitstun, block re-arm, freeze and reset.
module tb_hit_detect;

  localparam int X_W = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_tick, freeze;
  logic [X_W-1:0] pos1_x, pos2_x;
  logic           attack1_active, attack2_active, guard1, guard2;
  logic           hit1_lands, hit2_lands, blocked1, blocked2, stun1, stun2;

  int n_checks = 0;
  int n_errors = 0;

  hit_detect #(.X_W(X_W), .BODY_W(32), .REACH(40), .HITSTUN_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .freeze(freeze),
    .pos1_x(pos1_x), .pos2_x(pos2_x),
    .attack1_active(attack1_active), .attack2_active(attack2_active),
    .guard1(guard1), .guard2(guard2),
    .hit1_lands(hit1_lands), .hit2_lands(hit2_lands),
    .blocked1(blocked1), .blocked2(blocked2),
    .stun1(stun1), .stun2(stun2)
  );

  always #5 clk = ~clk;

  // Output bundle order: {hit1, hit2, blk1, blk2, stun1, stun2}
  function automatic logic [5:0] outs();
    return {hit1_lands, hit2_lands, blocked1, blocked2, stun1, stun2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; outputs are sampled at the same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic idle_inputs();
    frame_tick = 0; freeze = 0; attack1_active = 0; attack2_active = 0;
    guard1 = 0; guard2 = 0; pos1_x = 10'd100; pos2_x = 10'd170;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  typedef struct {
    string          name;
    logic [X_W-1:0] p1, p2;
    logic           a1, a2, g1, g2, frz;
    logic [5:0]     exp;
  } vec_t;

  vec_t vecs[$];
  int   hit_count;

  initial begin
    idle_inputs();
    reset = 1'b0;
    cyc();
    cyc();
    check("reset_outputs", 32'(outs()), 32'h0);
    reset = 1'b1;

    //          name          p1    p2   a1 a2 g1 g2 frz  {h1 h2 b1 b2 s1 s2}
    vecs.push_back('{"gap38_hit",    10'd100, 10'd170, 1,0,0,0,0, 6'b100001});
    vecs.push_back('{"gap39_hit",    10'd100, 10'd171, 1,0,0,0,0, 6'b100001});
    vecs.push_back('{"gap40_miss",   10'd100, 10'd172, 1,0,0,0,0, 6'b000000});
    vecs.push_back('{"overlap_hit",  10'd100, 10'd120, 1,0,0,0,0, 6'b100001});
    vecs.push_back('{"p2_left_hit",  10'd100, 10'd50,  1,0,0,0,0, 6'b100001});
    vecs.push_back('{"far_miss",     10'd0,   10'd1023,1,1,0,0,0, 6'b000000});
    vecs.push_back('{"wide_neg_hit", 10'd1023,10'd0,   0,1,0,0,0, 6'b010010});
    vecs.push_back('{"guard2_block", 10'd100, 10'd170, 1,0,0,1,0, 6'b001000});
    vecs.push_back('{"guard1_block", 10'd100, 10'd170, 0,1,1,0,0, 6'b000100});
    vecs.push_back('{"trade",        10'd100, 10'd170, 1,1,0,0,0, 6'b110011});
    vecs.push_back('{"trade_freeze", 10'd100, 10'd170, 1,1,0,0,1, 6'b000000});
    vecs.push_back('{"block_vs_hit", 10'd100, 10'd170, 1,1,0,1,0, 6'b011010});
    vecs.push_back('{"p2_gap40_miss",10'd100, 10'd172, 0,1,0,0,0, 6'b000000});
    vecs.push_back('{"idle_no_tick", 10'd100, 10'd170, 0,0,0,0,0, 6'b000000});

    foreach (vecs[i]) begin
      idle_inputs();
      do_reset();
      pos1_x = vecs[i].p1; pos2_x = vecs[i].p2;
      attack1_active = vecs[i].a1; attack2_active = vecs[i].a2;
      guard1 = vecs[i].g1; guard2 = vecs[i].g2; freeze = vecs[i].frz;
      tick();
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      cyc();
      // Pulses drop after one cycle; stun levels persist.
      check({vecs[i].name, "_next"}, 32'(outs()), 32'(vecs[i].exp & 6'b000011));
    end

    // One connection per attack: held 10 ticks -> exactly one hit1.
    idle_inputs(); do_reset();
    attack1_active = 1;
    hit_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hit1_lands) hit_count++;
      cyc();
      if (hit1_lands) hit_count++;
    end
    check("one_conn_count", 32'(hit_count), 32'd1);
    check("one_conn_stun2_clear", 32'(stun2), 32'd0);
    attack1_active = 0; cyc();
    attack1_active = 1; cyc();
    tick();
    check("rearm_hit", 32'(outs()), 32'(6'b100001));

    // Hitstun with HITSTUN_FRAMES=3: stun2 falls on tick k+3.
    idle_inputs(); do_reset();
    attack1_active = 1;
    tick();                                         // tick k
    check("stun_k", 32'(outs()), 32'(6'b100001));
    attack1_active = 0; cyc();
    attack1_active = 1; attack2_active = 1; cyc();
    tick();                                         // k+1
    check("stun_k1", 32'(outs()), 32'(6'b000001));
    cyc();
    tick();                                         // k+2
    check("stun_k2", 32'(outs()), 32'(6'b000001));
    attack2_active = 0; cyc();
    tick();                                         // k+3
    check("stun_k3_falls", 32'(outs()), 32'(6'b000000));
    cyc();
    tick();                                         // k+4, same active window
    check("late_connect", 32'(outs()), 32'(6'b100001));

    // Block then no repeat until re-armed.
    idle_inputs(); do_reset();
    attack1_active = 1; guard2 = 1;
    tick();
    check("blk_first", 32'(outs()), 32'(6'b001000));
    cyc();
    tick();
    check("blk_no_repeat", 32'(outs()), 32'(6'b000000));
    attack1_active = 0; cyc();
    attack1_active = 1; cyc();
    tick();
    check("blk_rearm", 32'(outs()), 32'(6'b001000));

    // Freeze does not halt stun countdown.
    idle_inputs(); do_reset();
    attack1_active = 1;
    tick();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tick();
    end
    check("freeze_stun_runs", 32'(outs()), 32'(6'b000000));

    // Reset mid-stun with conn1 set, then immediate re-hit.
    idle_inputs(); do_reset();
    attack1_active = 1;
    tick();
    cyc();
    check("pre_reset_stun", 32'(stun2), 32'd1);
    reset = 0;
    cyc();
    check("mid_reset_clear", 32'(outs()), 32'h0);
    reset = 1;
    cyc();
    tick();
    check("post_reset_hit", 32'(outs()), 32'(6'b100001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hit_detect.md
# hit_detect

Per-frame hit resolver for the two-player footsies arena. On each frame tick it compares each player's active attack hitbox against the opponent's hurtbox. It emits single-cycle `hit1_lands` / `hit2_lands` pulses that feed the health stage directly, plus `blocked1` / `blocked2` pulses. It enforces one connection per attack and tracks per-player hitstun, during which the stunned player can neither be hit nor land a hit.

## Interface
- `X_W`, 10: width of the horizontal position buses.
- `BODY_W`, 32: hurtbox width in pixels, measured from the player's left edge.
- `REACH`, 40: attack reach in pixels beyond the attacker's facing body edge.
- `HITSTUN_FRAMES`, 20: stun length in frame ticks after being hit; range 1..255.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-low; asserted when 0, sampled on the rising edge of `clk`.
- `frame_tick` input 1: one-cycle strobe, once per video frame; the only evaluation point.
- `freeze` input 1: high suppresses all new hits and blocks (driven from game over).
- `pos1_x` input X_W: P1 left edge. P1 always faces right.
- `pos2_x` input X_W: P2 left edge. P2 always faces left.
- `attack1_active`, `attack2_active` input 1: attack is in its active phase; level signal.
- `guard1`, `guard2` input 1: player is holding guard.
- `hit1_lands` output 1: P1 hit P2; one-cycle pulse.
- `hit2_lands` output 1: P2 hit P1; one-cycle pulse.
- `blocked1` output 1: P1's attack was guarded by P2; one-cycle pulse.
- `blocked2` output 1: P2's attack was guarded by P1; one-cycle pulse.
- `stun1`, `stun2` output 1: player is in hitstun.

## Operation
- Gap: `gap = pos2_x - (pos1_x + BODY_W)`, computed signed at X_W+2 bits. A negative gap (bodies overlapping) counts as in range.
- In range when `gap < REACH`. The condition is symmetric, so it applies to both attackers.
- State per player N:
  - `conn_N`: this attack has already connected.
  - `stun_cnt_N`: 8-bit counter.
- Candidate for player N requires all of the following, sampled on a cycle with `frame_tick` = 1:
  - `attack_N_active` is high.
  - `conn_N` = 0.
  - `stun_cnt_N` = 0.
  - `stun_cnt` of the opponent = 0.
  - In range.
  - `freeze` = 0.
- Candidate with the opponent not guarding:
  - Pulse `hitN_lands`.
  - Set `conn_N`.
  - Load the opponent's `stun_cnt` with HITSTUN_FRAMES.
- Candidate with the opponent guarding:
  - Pulse `blockedN`.
  - Set `conn_N`.
  - No stun load.
- An attack into a stunned opponent is ignored and leaves `conn_N` unchanged, so it may connect later in the same active window.
- `conn_N` clears on any cycle where `attack_N_active` = 0, regardless of `frame_tick`.
- `stun_cnt_N` decrements by 1 on `frame_tick` when nonzero and not being loaded that cycle. A load overrides the decrement. The counter saturates at 0.
- Trade: both candidates are evaluated against pre-update state. When both qualify, both pulses fire in the same cycle and both stun counters load.
- `stunN` = (`stun_cnt_N` != 0), decoded from registers.
- Reset (`reset` = 0) clears all state:
  - Every output is 0.
  - `conn` = 0.
  - `stun_cnt` = 0.
  - Reset mid-stun or mid-attack discards all progress.

## Timing
- Evaluation happens only on `frame_tick` cycles. Inputs are sampled at that edge.
- A frame tick sampled at edge t produces a hit/block pulse high from t until t+1, exactly one cycle.
- `stunN` rises in the same cycle as the causing `hit_lands` pulse. It stays high for HITSTUN_FRAMES frame ticks, then falls on the edge of the HITSTUN_FRAMES-th subsequent tick.
- Pulse outputs are never high two cycles in a row; `frame_tick` is at least 2 cycles apart.
- `freeze` takes effect on the same sampled edge. `freeze` does not stop stun counters.
- Latency between `attack_active` rising and the hit is 0 frames when already in range at the next tick.

## Test plan
- Range edge (BODY_W=32, REACH=40, pos1=100, P1 attack held, tick):
  - pos2=170 (gap 38) -> `hit1_lands` pulse, `stun2`=1.
  - pos2=172 (gap 40) -> no pulse.
  - pos2=120 (overlap) -> pulse.
- One connection per attack: `attack1_active` held 10 ticks in range -> exactly one `hit1_lands`. Drop for 1 cycle, re-raise after `stun2` clears -> second pulse.
- Hitstun: with HITSTUN_FRAMES=3, a hit at tick k -> `stun2` high until tick k+3. P1 attacks during ticks k+1..k+2 -> no pulse. P2 attack in range during stun -> no `hit2_lands`.
- Guard: `guard2`=1 with P1 in range -> `blocked1` pulse, no `hit1_lands`, `stun2` stays 0, no further `blocked1` until the attack re-arms.
- Trade and freeze: both attacks active, in range, same tick -> `hit1_lands` and `hit2_lands` in the same cycle, both stuns set. Repeat with `freeze`=1 -> no pulses.
- Reset: assert `reset`=0 mid-stun with `conn1` set -> next cycle all outputs 0. After release, a new in-range attack hits on its first tick.
